// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: BCD digit width, default clock
// rate, gate-counter sizing helper and the measurement FSM state encoding.
package freq_meter_pkg;

    localparam int BCD_W          = 4;
    localparam int CLK_HZ_DEFAULT = 50000000;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Width of a counter that runs 0..gate_cycles-1 (never narrower than 1 bit).
    function automatic int gate_cnt_w(input int gate_cycles);
        return (gate_cycles > 1) ? $clog2(gate_cycles) : 1;
    endfunction

endpackage

// File: rtl/freq_meter_bcd_decade.sv
// One decimal decade of the working edge counter. Counts 0..9 on inc and
// reports a carry when it rolls over from 9 to 0. clr wins over inc.
module bcd_decade
    import freq_meter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    // Decade register: clear, or step with 9 -> 0 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end
    end

    // Carry into the next decade when this one wraps.
    always_comb begin
        carry = inc & (digit == 4'd9);
    end

endmodule

// File: rtl/freq_meter.sv
// Frequency meter: counts synchronised rising edges of sig_in over a gate
// window of GATE_CYCLES clk cycles and publishes the count as packed BCD.
//
// Output handshake: valid is a one-cycle strobe with no back-pressure (no
// ready). bcd/overflow change only in the cycle valid is high and then hold,
// so a consumer may capture them on the strobe or at any later time.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int DIGITS      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    sig_in,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    overflow,
    output logic                    valid,
    output logic                    busy
);

    localparam int             GW        = gate_cnt_w(GATE_CYCLES);
    localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);

    logic sync1, sync2, sync3;
    logic edge_pulse;

    state_t state_q, state_d;

    logic [GW-1:0] gate_q;
    logic          measuring;
    logic          terminal;
    logic          clr;
    logic          inc_raw;
    logic          all_nines;

    logic [DIGITS:0]             carry_chain;
    logic [DIGITS-1:0]           dec_nine;
    logic [BCD_W*DIGITS-1:0]     work;
    logic [BCD_W*DIGITS-1:0]     work_next;
    logic                        sticky_q;
    logic                        sticky_next;

    logic [BCD_W*DIGITS-1:0]     bcd_q;
    logic                        ovf_q;
    logic                        valid_q;

    // Two-flop synchroniser plus a third stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_pulse = sync2 & ~sync3;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: en alone moves between idle and measuring.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)  state_d = MEASURE;
            MEASURE: if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == MEASURE);
    end

    // Window control: a cycle with en low in MEASURE abandons the window.
    always_comb begin
        measuring = (state_q == MEASURE) && en;
        terminal  = measuring && (gate_q == GATE_LAST);
        clr       = !measuring || terminal;
        inc_raw   = measuring && edge_pulse;
        all_nines = &dec_nine;
    end

    // Gate counter: 0 in the first MEASURE cycle, wraps after GATE_LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q <= '0;
        end else if (clr) begin
            gate_q <= '0;
        end else begin
            gate_q <= gate_q + GW'(1);
        end
    end

    // Least significant decade is fed by the edge, gated off at all 9s so
    // the count saturates instead of wrapping.
    assign carry_chain[0] = inc_raw & ~all_nines;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_decade
            bcd_decade u_decade (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .inc   (carry_chain[gi]),
                .digit (work[gi*BCD_W +: BCD_W]),
                .carry (carry_chain[gi+1])
            );

            // Value each decade would hold after this cycle's increment,
            // so the terminal cycle's own edge lands in the result.
            always_comb begin
                dec_nine[gi] = (work[gi*BCD_W +: BCD_W] == 4'd9);
                if (carry_chain[gi]) begin
                    work_next[gi*BCD_W +: BCD_W] = dec_nine[gi] ? 4'd0
                                                 : work[gi*BCD_W +: BCD_W] + 4'd1;
                end else begin
                    work_next[gi*BCD_W +: BCD_W] = work[gi*BCD_W +: BCD_W];
                end
            end
        end
    endgenerate

    // Overflow marks an edge lost to saturation. A carry out of the top
    // decade cannot occur while the gating holds; folding it in keeps the
    // flag conservative.
    always_comb begin
        sticky_next = sticky_q | (inc_raw & all_nines) | carry_chain[DIGITS];
    end

    // Sticky window-overflow bit, cleared with the working count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (clr) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_next;
        end
    end

    // Result registers: load on the terminal cycle, strobe valid after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= terminal;
            if (terminal) begin
                bcd_q <= work_next;
                ovf_q <= sticky_next;
            end
        end
    end

    assign bcd      = bcd_q;
    assign overflow = ovf_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter. Instance A: GATE_CYCLES=100, DIGITS=4.
// Instance B: GATE_CYCLES=1000, DIGITS=2 for saturation. Both see the same
// sig_in, produced by a small square-wave generator.
module tb_freq_meter;

    logic        clk;
    logic        rst_n;
    logic        sig_in;
    logic        en_a, en_b;
    logic [15:0] bcd_a;
    logic [7:0]  bcd_b;
    logic        ovf_a, ovf_b;
    logic        valid_a, valid_b;
    logic        busy_a, busy_b;

    int tests = 0;
    int fails = 0;

    int   sig_period = 0;
    int   sig_high   = 0;
    logic sig_const  = 1'b0;

    freq_meter #(.CLK_HZ(100), .GATE_CYCLES(100), .DIGITS(4)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en_a),
        .sig_in   (sig_in),
        .bcd      (bcd_a),
        .overflow (ovf_a),
        .valid    (valid_a),
        .busy     (busy_a)
    );

    freq_meter #(.CLK_HZ(1000), .GATE_CYCLES(1000), .DIGITS(2)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en_b),
        .sig_in   (sig_in),
        .bcd      (bcd_b),
        .overflow (ovf_b),
        .valid    (valid_b),
        .busy     (busy_b)
    );

    // Clock: period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Square-wave source, updated 2 time units after a rising clk edge.
    initial begin
        sig_in = 1'b0;
        forever begin
            if (sig_period == 0) begin
                sig_in = sig_const;
                @(posedge clk);
                #2;
            end else begin
                sig_in = 1'b1;
                repeat (sig_high) @(posedge clk);
                #2;
                sig_in = 1'b0;
                repeat (sig_period - sig_high) @(posedge clk);
                #2;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait on falling edges for valid of instance A (sel=0) or B (sel=1).
    // n = falling edges waited, or -1 if the budget ran out.
    task automatic wait_valid(input bit sel, input int maxc, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < maxc) begin
            @(negedge clk);
            n++;
            seen = sel ? valid_b : valid_a;
        end
        if (!seen) n = -1;
    endtask

    initial begin
        int n;
        int vcnt;
        logic ok;

        rst_n = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        sig_period = 10;
        sig_high   = 5;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_bcd",   {16'd0, bcd_a}, 32'h0);
        check("rst_ovf",   {31'd0, ovf_a}, 32'h0);
        check("rst_valid", {31'd0, valid_a}, 32'h0);
        check("rst_busy",  {31'd0, busy_a}, 32'h0);

        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'd0, busy_a}, 32'h0);

        // Period 10: first window latency, then 10 edges per window.
        en_a = 1'b1;
        @(negedge clk);
        check("start_busy", {31'd0, busy_a}, 32'h1);
        wait_valid(1'b0, 150, n);
        check("win1_lat", n, 32'd100);
        wait_valid(1'b0, 150, n);
        check("p10_gap", n, 32'd100);
        check("p10_bcd", {16'd0, bcd_a}, 32'h0010);
        check("p10_ovf", {31'd0, ovf_a}, 32'h0);
        wait_valid(1'b0, 150, n);
        check("p10_gap2", n, 32'd100);
        check("p10_bcd2", {16'd0, bcd_a}, 32'h0010);
        @(negedge clk);
        check("valid_width", {31'd0, valid_a}, 32'h0);

        // Abandon a window around gate count 50 for 30 cycles.
        repeat (48) @(negedge clk);
        en_a = 1'b0;
        vcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid_a) vcnt++;
        end
        check("abandon_novalid", vcnt, 32'd0);
        check("abandon_busy", {31'd0, busy_a}, 32'h0);
        check("abandon_bcd", {16'd0, bcd_a}, 32'h0010);
        check("abandon_ovf", {31'd0, ovf_a}, 32'h0);
        en_a = 1'b1;
        @(negedge clk);
        check("reen_busy", {31'd0, busy_a}, 32'h1);
        wait_valid(1'b0, 150, n);
        check("reen_lat", n, 32'd100);
        check("reen_bcd", {16'd0, bcd_a}, 32'h0010);

        // Constant 0, then constant 1: no edges in a settled window.
        sig_period = 0;
        sig_const  = 1'b0;
        wait_valid(1'b0, 150, n);
        wait_valid(1'b0, 150, n);
        check("c0_gap", n, 32'd100);
        check("c0_bcd", {16'd0, bcd_a}, 32'h0000);
        check("c0_ovf", {31'd0, ovf_a}, 32'h0);
        sig_const = 1'b1;
        wait_valid(1'b0, 150, n);
        wait_valid(1'b0, 150, n);
        check("c1_gap", n, 32'd100);
        check("c1_bcd", {16'd0, bcd_a}, 32'h0000);

        // Toggle every clk: 50 edges per 100-cycle window.
        sig_period = 2;
        sig_high   = 1;
        wait_valid(1'b0, 150, n);
        wait_valid(1'b0, 150, n);
        check("p2_gap", n, 32'd100);
        check("p2_bcd", {16'd0, bcd_a}, 32'h0050);
        wait_valid(1'b0, 150, n);
        check("p2_bcd2", {16'd0, bcd_a}, 32'h0050);

        // Period 3 (high 1, low 2): 33 or 34 edges depending on phase.
        sig_period = 3;
        sig_high   = 1;
        wait_valid(1'b0, 150, n);
        wait_valid(1'b0, 150, n);
        ok = (bcd_a == 16'h0033) || (bcd_a == 16'h0034);
        check("p3_bcd", {31'd0, ok}, 32'h1);
        wait_valid(1'b0, 150, n);
        ok = (bcd_a == 16'h0033) || (bcd_a == 16'h0034);
        check("p3_bcd2", {31'd0, ok}, 32'h1);
        check("p3_ovf", {31'd0, ovf_a}, 32'h0);

        // Asynchronous reset mid-window.
        sig_period = 10;
        sig_high   = 5;
        repeat (40) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_bcd",   {16'd0, bcd_a}, 32'h0);
        check("mrst_ovf",   {31'd0, ovf_a}, 32'h0);
        check("mrst_valid", {31'd0, valid_a}, 32'h0);
        check("mrst_busy",  {31'd0, busy_a}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_rebusy", {31'd0, busy_a}, 32'h1);
        wait_valid(1'b0, 150, n);
        check("mrst_lat", n, 32'd100);
        wait_valid(1'b0, 150, n);
        check("mrst_gap", n, 32'd100);
        check("mrst_bcd2", {16'd0, bcd_a}, 32'h0010);
        check("mrst_ovf2", {31'd0, ovf_a}, 32'h0);

        // Saturation on the 2-digit instance: 250 edges -> 99 with overflow.
        en_a = 1'b0;
        sig_period = 4;
        sig_high   = 2;
        en_b = 1'b1;
        @(negedge clk);
        check("b_busy", {31'd0, busy_b}, 32'h1);
        wait_valid(1'b1, 1100, n);
        check("b_lat", n, 32'd1000);
        check("b_sat_bcd", {24'd0, bcd_b}, 32'h99);
        check("b_sat_ovf", {31'd0, ovf_b}, 32'h1);

        // Slower input: 10 edges, overflow cleared.
        sig_period = 100;
        sig_high   = 50;
        wait_valid(1'b1, 1100, n);
        wait_valid(1'b1, 1100, n);
        check("b_gap", n, 32'd1000);
        check("b_p100_bcd", {24'd0, bcd_b}, 32'h10);
        check("b_p100_ovf", {31'd0, ovf_b}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
